// File: rtl/hdl_watchdog_timer.sv
// hdl_watchdog_timer
//   HDL-side watchdog counter feeding the truss watchdog interface. Counts
//   prescaled clock ticks against a limit sampled from hdl_timeout_count_.
//   When the limit is reached it raises hdl_timeout_ for the truss watchdog.
//   Supports heartbeat kicks, explicit acknowledge and a saturating count
//   of expiries.
//
// Ports
//   clk                 single clock, rising edge
//   reset_n             synchronous active-low reset
//   hdl_timeout_count_  timeout limit in ticks (0 = never expire)
//   enable              arm request, level-sensitive
//   kick                heartbeat, restarts the count and re-samples the limit
//   clear               acknowledges an expiry
//   hdl_timeout_        registered timeout flag
//   count               current tick count
//   state               0 = IDLE, 1 = RUN, 2 = EXPIRED
//   timeout_events      expiries since reset, saturating
module hdl_watchdog_timer #(
    parameter int unsigned COUNTER_WIDTH = 32,
    parameter int unsigned PRESCALE      = 1,
    parameter int unsigned EVENT_WIDTH   = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [COUNTER_WIDTH-1:0] hdl_timeout_count_,
    input  logic                     enable,
    input  logic                     kick,
    input  logic                     clear,
    output logic                     hdl_timeout_,
    output logic [COUNTER_WIDTH-1:0] count,
    output logic [1:0]               state,
    output logic [EVENT_WIDTH-1:0]   timeout_events
);

    localparam int unsigned PW = $clog2(PRESCALE) + 1;
    localparam logic [PW-1:0] PS_MAX = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_EXPIRED = 2'd2
    } state_e;

    state_e                   state_q, state_d;
    logic [COUNTER_WIDTH-1:0] count_q, count_d;
    logic [COUNTER_WIDTH-1:0] limit_q, limit_d;
    logic [PW-1:0]            presc_q, presc_d;
    logic                     timeout_q, timeout_d;
    logic [EVENT_WIDTH-1:0]   events_q, events_d;

    // One extra bit so an all-ones limit compares without wrapping.
    logic [COUNTER_WIDTH:0]   count_inc;
    assign count_inc = {1'b0, count_q} + (COUNTER_WIDTH+1)'(1);

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            limit_q   <= '0;
            presc_q   <= '0;
            timeout_q <= 1'b0;
            events_q  <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            limit_q   <= limit_d;
            presc_q   <= presc_d;
            timeout_q <= timeout_d;
            events_q  <= events_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        limit_d   = limit_q;
        presc_d   = presc_q;
        timeout_d = timeout_q;
        events_d  = events_q;
        unique case (state_q)
            ST_IDLE: begin
                count_d = '0;
                presc_d = '0;
                if (enable) begin
                    state_d = ST_RUN;
                    limit_d = hdl_timeout_count_;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                    count_d = '0;
                    presc_d = '0;
                end else if (kick) begin
                    // Kick wins over an expiry due on the same edge.
                    count_d = '0;
                    presc_d = '0;
                    limit_d = hdl_timeout_count_;
                end else if (presc_q == PS_MAX) begin
                    presc_d = '0;
                    if (limit_q == '0) begin
                        // Free-running: saturate instead of wrapping.
                        if (count_q != '1) count_d = count_inc[COUNTER_WIDTH-1:0];
                    end else begin
                        count_d = count_inc[COUNTER_WIDTH-1:0];
                        if (count_inc == {1'b0, limit_q}) begin
                            state_d   = ST_EXPIRED;
                            timeout_d = 1'b1;
                            if (events_q != '1) events_d = events_q + EVENT_WIDTH'(1);
                        end
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            ST_EXPIRED: begin
                if (clear) begin
                    state_d   = ST_IDLE;
                    timeout_d = 1'b0;
                    count_d   = '0;
                    presc_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs straight from registers
    always_comb begin
        hdl_timeout_   = timeout_q;
        count          = count_q;
        state          = state_q;
        timeout_events = events_q;
    end

endmodule

// File: tb/tb_hdl_watchdog_timer.sv
module tb_hdl_watchdog_timer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] limit;
    logic        enable, kick, clear;

    logic        m_to, p_to, s_to;
    logic [31:0] m_cnt, p_cnt;
    logic [3:0]  s_cnt;
    logic [1:0]  m_st, p_st, s_st;
    logic [7:0]  m_ev, p_ev;
    logic [1:0]  s_ev;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hdl_watchdog_timer #(.COUNTER_WIDTH(32), .PRESCALE(1), .EVENT_WIDTH(8)) u_main (
        .clk(clk), .reset_n(reset_n), .hdl_timeout_count_(limit), .enable(enable),
        .kick(kick), .clear(clear), .hdl_timeout_(m_to), .count(m_cnt),
        .state(m_st), .timeout_events(m_ev));

    hdl_watchdog_timer #(.COUNTER_WIDTH(32), .PRESCALE(4), .EVENT_WIDTH(8)) u_p4 (
        .clk(clk), .reset_n(reset_n), .hdl_timeout_count_(limit), .enable(enable),
        .kick(kick), .clear(clear), .hdl_timeout_(p_to), .count(p_cnt),
        .state(p_st), .timeout_events(p_ev));

    hdl_watchdog_timer #(.COUNTER_WIDTH(4), .PRESCALE(1), .EVENT_WIDTH(2)) u_small (
        .clk(clk), .reset_n(reset_n), .hdl_timeout_count_(limit[3:0]), .enable(enable),
        .kick(kick), .clear(clear), .hdl_timeout_(s_to), .count(s_cnt),
        .state(s_st), .timeout_events(s_ev));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; enable = 1'b0; kick = 1'b0; clear = 1'b0; limit = '0;
        tick(); tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({m_to, m_cnt, m_st, m_ev} !== '0) begin
            n_fail++;
            $display("FAIL reset_main: to=%0b cnt=%0d st=%0d ev=%0d, required all 0", m_to, m_cnt, m_st, m_ev);
        end
        n_checks++;
        if ({p_to, p_cnt, p_st, s_to, s_cnt, s_st} !== '0) begin
            n_fail++;
            $display("FAIL reset_others: p_st=%0d s_st=%0d, required 0", p_st, s_st);
        end
    endtask

    task automatic test_basic();
        do_reset();
        limit = 32'd5; enable = 1'b1;
        tick();
        n_checks++;
        if (m_st !== 2'd1 || m_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL basic_arm: st=%0d cnt=%0d, required st=1 cnt=0", m_st, m_cnt);
        end
        for (int i = 1; i <= 4; i++) begin
            tick();
            n_checks++;
            if (m_cnt !== 32'(i) || m_to !== 1'b0) begin
                n_fail++;
                $display("FAIL basic_count: edge %0d cnt=%0d to=%0b, required cnt=%0d to=0", i, m_cnt, m_to, i);
            end
        end
        tick();
        n_checks++;
        if (m_to !== 1'b1 || m_st !== 2'd2 || m_ev !== 8'd1 || m_cnt !== 32'd5) begin
            n_fail++;
            $display("FAIL basic_expire: to=%0b st=%0d ev=%0d cnt=%0d, required 1/2/1/5", m_to, m_st, m_ev, m_cnt);
        end
        kick = 1'b1;
        tick(); tick();
        kick = 1'b0;
        n_checks++;
        if (m_st !== 2'd2 || m_to !== 1'b1 || m_cnt !== 32'd5) begin
            n_fail++;
            $display("FAIL expired_hold: st=%0d to=%0b cnt=%0d, required 2/1/5", m_st, m_to, m_cnt);
        end
    endtask

    task automatic test_prescale();
        do_reset();
        limit = 32'd3; enable = 1'b1;
        tick();
        for (int e = 1; e <= 12; e++) begin
            tick();
            n_checks++;
            if (p_cnt !== 32'(e / 4) || p_to !== (e == 12)) begin
                n_fail++;
                $display("FAIL prescale: edge %0d cnt=%0d to=%0b, required cnt=%0d to=%0b", e, p_cnt, p_to, e / 4, (e == 12));
            end
        end
    endtask

    task automatic test_kick();
        do_reset();
        limit = 32'd5; enable = 1'b1;
        tick();
        tick(); tick(); tick();
        kick = 1'b1;
        tick();
        kick = 1'b0;
        n_checks++;
        if (m_cnt !== 32'd0 || m_st !== 2'd1) begin
            n_fail++;
            $display("FAIL kick_first: cnt=%0d st=%0d, required 0/1", m_cnt, m_st);
        end
        tick(); tick(); tick(); tick();
        n_checks++;
        if (m_cnt !== 32'd4) begin
            n_fail++;
            $display("FAIL kick_recount: cnt=%0d, required 4", m_cnt);
        end
        limit = 32'd2; kick = 1'b1;
        tick();
        kick = 1'b0;
        n_checks++;
        if (m_to !== 1'b0 || m_st !== 2'd1 || m_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL kick_override: to=%0b st=%0d cnt=%0d, required 0/1/0", m_to, m_st, m_cnt);
        end
        tick();
        n_checks++;
        if (m_to !== 1'b0 || m_cnt !== 32'd1) begin
            n_fail++;
            $display("FAIL kick_new_limit_1: to=%0b cnt=%0d, required 0/1", m_to, m_cnt);
        end
        tick();
        n_checks++;
        if (m_to !== 1'b1 || m_cnt !== 32'd2) begin
            n_fail++;
            $display("FAIL kick_new_limit_2: to=%0b cnt=%0d, required 1/2", m_to, m_cnt);
        end
    endtask

    task automatic test_clear_kick();
        do_reset();
        limit = 32'd2; enable = 1'b1;
        tick(); tick(); tick();
        n_checks++;
        if (m_st !== 2'd2 || m_ev !== 8'd1) begin
            n_fail++;
            $display("FAIL clr_setup: st=%0d ev=%0d, required 2/1", m_st, m_ev);
        end
        clear = 1'b1; kick = 1'b1;
        tick();
        clear = 1'b0; kick = 1'b0;
        n_checks++;
        if (m_st !== 2'd0 || m_to !== 1'b0 || m_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL clr_wins: st=%0d to=%0b cnt=%0d, required 0/0/0", m_st, m_to, m_cnt);
        end
        tick();
        n_checks++;
        if (m_st !== 2'd1) begin
            n_fail++;
            $display("FAIL clr_rearm: st=%0d, required 1", m_st);
        end
        tick(); tick();
        n_checks++;
        if (m_st !== 2'd2 || m_to !== 1'b1 || m_ev !== 8'd2) begin
            n_fail++;
            $display("FAIL clr_second: st=%0d to=%0b ev=%0d, required 2/1/2", m_st, m_to, m_ev);
        end
    endtask

    task automatic test_limit_zero();
        int saw_to;
        do_reset();
        limit = 32'd0; enable = 1'b1;
        tick();
        saw_to = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (m_to === 1'b1 || s_to === 1'b1) saw_to++;
        end
        n_checks++;
        if (saw_to != 0) begin
            n_fail++;
            $display("FAIL zero_no_expire: timeout seen %0d times, required 0", saw_to);
        end
        n_checks++;
        if (m_cnt !== 32'd300 || m_st !== 2'd1) begin
            n_fail++;
            $display("FAIL zero_count: cnt=%0d st=%0d, required 300/1", m_cnt, m_st);
        end
        n_checks++;
        if (s_cnt !== 4'hF || s_st !== 2'd1) begin
            n_fail++;
            $display("FAIL zero_saturate: cnt=%0d st=%0d, required 15/1", s_cnt, s_st);
        end
    endtask

    task automatic test_limit_max();
        do_reset();
        limit = 32'd15; enable = 1'b1;
        tick();
        for (int i = 0; i < 14; i++) tick();
        n_checks++;
        if (s_to !== 1'b0 || s_cnt !== 4'd14) begin
            n_fail++;
            $display("FAIL max_before: to=%0b cnt=%0d, required 0/14", s_to, s_cnt);
        end
        tick();
        n_checks++;
        if (s_to !== 1'b1 || s_cnt !== 4'd15 || s_st !== 2'd2) begin
            n_fail++;
            $display("FAIL max_expire: to=%0b cnt=%0d st=%0d, required 1/15/2", s_to, s_cnt, s_st);
        end
        limit = 32'd1;
        for (int k = 0; k < 3; k++) begin
            clear = 1'b1; tick();
            clear = 1'b0; tick();
            tick();
        end
        n_checks++;
        if (s_ev !== 2'd3 || s_st !== 2'd2) begin
            n_fail++;
            $display("FAIL events_saturate: ev=%0d st=%0d, required 3/2", s_ev, s_st);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        limit = 32'd10; enable = 1'b1;
        tick(); tick(); tick(); tick();
        n_checks++;
        if (m_cnt !== 32'd3) begin
            n_fail++;
            $display("FAIL rst_run_setup: cnt=%0d, required 3", m_cnt);
        end
        reset_n = 1'b0;
        tick();
        n_checks++;
        if ({m_to, m_cnt, m_st, m_ev} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_run: to=%0b cnt=%0d st=%0d ev=%0d, required all 0", m_to, m_cnt, m_st, m_ev);
        end
        reset_n = 1'b1;
        tick();
        n_checks++;
        if (m_st !== 2'd1 || m_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_run_rearm: st=%0d cnt=%0d, required 1/0", m_st, m_cnt);
        end
        do_reset();
        limit = 32'd2; enable = 1'b1;
        tick(); tick(); tick();
        n_checks++;
        if (m_st !== 2'd2 || m_ev !== 8'd1) begin
            n_fail++;
            $display("FAIL rst_exp_setup: st=%0d ev=%0d, required 2/1", m_st, m_ev);
        end
        reset_n = 1'b0;
        tick();
        n_checks++;
        if ({m_to, m_cnt, m_st, m_ev} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_expired: to=%0b cnt=%0d st=%0d ev=%0d, required all 0", m_to, m_cnt, m_st, m_ev);
        end
        reset_n = 1'b1;
        tick();
        n_checks++;
        if (m_st !== 2'd1 || m_to !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_exp_rearm: st=%0d to=%0b, required 1/0", m_st, m_to);
        end
    endtask

    initial begin
        reset_n = 1'b0; enable = 1'b0; kick = 1'b0; clear = 1'b0; limit = '0;
        test_reset();
        test_basic();
        test_prescale();
        test_kick();
        test_clear_kick();
        test_limit_zero();
        test_limit_max();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
